// File: rtl/mem_stage_if.sv
// Data-memory bus between mem_stage (master) and the data memory (slave).
// Request is held until a one-cycle ack; read data is valid with ack.
interface mem_stage_if;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rw;
   logic        mem_req;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_addr, mem_wdata, mem_rw, mem_req,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_rw, mem_req,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: passes ALU results through, or runs one blocking memory access.
// Optional access timeout with fault pulse when MEM_STAGE_TIMEOUT_EN is defined.
module mem_stage (
   input  logic               clock,
   input  logic               reset,
   input  logic               ex_mem_readmem,
   input  logic               ex_mem_writemem,
   input  logic [31:0]        ex_mem_regb,
   input  logic               ex_mem_selwsource,
   input  logic [4:0]         ex_mem_regdest,
   input  logic               ex_mem_writereg,
   input  logic [31:0]        ex_mem_wbvalue,
   mem_stage_if.master        mem,
   output logic               mem_stall,
   output logic [4:0]         mem_wb_regdest,
   output logic               mem_wb_writereg,
   output logic [31:0]        mem_wb_wbvalue,
   output logic               mem_fault
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_q, state_d;
   logic        start, finish, expire;
   logic [31:0] addr_q, wdata_q;
   logic        rw_q, req_q;
   logic [4:0]  cap_regdest_q;
   logic        cap_selw_q, cap_writereg_q;

`ifdef MEM_STAGE_TIMEOUT_EN
   logic [3:0]  tmo_cnt_q;
`endif

   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign mem.mem_rw    = rw_q;
   assign mem.mem_req   = req_q;
   assign mem_stall     = (state_q == BUSY);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      finish  = 1'b0;
      expire  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ex_mem_readmem || ex_mem_writemem) begin
               start   = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (mem.mem_ack) begin
               finish  = 1'b1;
               state_d = IDLE;
            end
`ifdef MEM_STAGE_TIMEOUT_EN
            else if (tmo_cnt_q == 4'hF) begin
               expire  = 1'b1;
               state_d = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_q          <= '0;
         wdata_q         <= '0;
         rw_q            <= 1'b0;
         req_q           <= 1'b0;
         cap_regdest_q   <= '0;
         cap_selw_q      <= 1'b0;
         cap_writereg_q  <= 1'b0;
         mem_wb_regdest  <= '0;
         mem_wb_writereg <= 1'b0;
         mem_wb_wbvalue  <= '0;
      end else if (start) begin
         addr_q          <= ex_mem_wbvalue;
         wdata_q         <= ex_mem_regb;
         rw_q            <= ex_mem_writemem;
         req_q           <= 1'b1;
         cap_regdest_q   <= ex_mem_regdest;
         cap_selw_q      <= ex_mem_selwsource;
         cap_writereg_q  <= ex_mem_writereg;
         mem_wb_writereg <= 1'b0;
      end else if (state_q == IDLE) begin
         mem_wb_regdest  <= ex_mem_regdest;
         mem_wb_writereg <= ex_mem_writereg;
         mem_wb_wbvalue  <= ex_mem_wbvalue;
      end else if (finish) begin
         req_q           <= 1'b0;
         mem_wb_regdest  <= cap_regdest_q;
         mem_wb_writereg <= cap_writereg_q;
         mem_wb_wbvalue  <= cap_selw_q ? mem.mem_rdata : addr_q;
      end else begin
         // timeout drops the request without any writeback
         if (expire) req_q <= 1'b0;
         mem_wb_writereg <= 1'b0;
      end
   end

`ifdef MEM_STAGE_TIMEOUT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tmo_cnt_q <= '0;
         mem_fault <= 1'b0;
      end else begin
         mem_fault <= expire;
         if (start)                                    tmo_cnt_q <= '0;
         else if (state_q == BUSY && !mem.mem_ack)     tmo_cnt_q <= tmo_cnt_q + 4'd1;
      end
   end
`else
   assign mem_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writebacks queued at issue, popped at writeback.
module tb_mem_stage;
   logic        clock = 1'b0;
   logic        reset;
   logic        ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource, ex_mem_writereg;
   logic [31:0] ex_mem_regb, ex_mem_wbvalue;
   logic [4:0]  ex_mem_regdest;
   logic        mem_stall, mem_wb_writereg, mem_fault;
   logic [4:0]  mem_wb_regdest;
   logic [31:0] mem_wb_wbvalue;

   mem_stage_if mbus();

   mem_stage dut (
      .clock             (clock),
      .reset             (reset),
      .ex_mem_readmem    (ex_mem_readmem),
      .ex_mem_writemem   (ex_mem_writemem),
      .ex_mem_regb       (ex_mem_regb),
      .ex_mem_selwsource (ex_mem_selwsource),
      .ex_mem_regdest    (ex_mem_regdest),
      .ex_mem_writereg   (ex_mem_writereg),
      .ex_mem_wbvalue    (ex_mem_wbvalue),
      .mem               (mbus.master),
      .mem_stall         (mem_stall),
      .mem_wb_regdest    (mem_wb_regdest),
      .mem_wb_writereg   (mem_wb_writereg),
      .mem_wb_wbvalue    (mem_wb_wbvalue),
      .mem_fault         (mem_fault)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] v;
   } wb_t;

   wb_t sb[$];
   wb_t mon_e;
   int  total = 0;
   int  bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clock) begin
      if (reset === 1'b1 && mem_wb_writereg === 1'b1) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_wb", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("sb_regdest", {27'd0, mem_wb_regdest}, {27'd0, mon_e.rd});
            check("sb_wbvalue", mem_wb_wbvalue, mon_e.v);
         end
      end
   end

   task automatic idle_inputs();
      ex_mem_readmem    = 1'b0;
      ex_mem_writemem   = 1'b0;
      ex_mem_writereg   = 1'b0;
      ex_mem_selwsource = 1'b0;
      ex_mem_regb       = '0;
      ex_mem_wbvalue    = '0;
      ex_mem_regdest    = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic alu_op(input logic [4:0] rd, input logic [31:0] val, input logic wr);
      ex_mem_readmem  = 1'b0;
      ex_mem_writemem = 1'b0;
      ex_mem_regdest  = rd;
      ex_mem_wbvalue  = val;
      ex_mem_writereg = wr;
      if (wr) sb.push_back('{rd: rd, v: val});
      tick();
      check("alu_stall", {31'd0, mem_stall}, 32'd0);
      check("alu_wreg", {31'd0, mem_wb_writereg}, {31'd0, wr});
      check("alu_value", mem_wb_wbvalue, val);
      idle_inputs();
   endtask

   task automatic mem_op(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                         input logic [31:0] regb, input logic sel, input logic [4:0] dest,
                         input logic wreg, input int unsigned ack_delay, input logic [31:0] rdata);
      int unsigned stall_cnt;
      ex_mem_readmem    = rd_en;
      ex_mem_writemem   = wr_en;
      ex_mem_wbvalue    = addr;
      ex_mem_regb       = regb;
      ex_mem_selwsource = sel;
      ex_mem_regdest    = dest;
      ex_mem_writereg   = wreg;
      if (wreg) sb.push_back('{rd: dest, v: (sel ? rdata : addr)});
      tick();
      stall_cnt = 0;
      check("req_set", {31'd0, mbus.mem_req}, 32'd1);
      check("req_rw", {31'd0, mbus.mem_rw}, {31'd0, wr_en});
      check("req_addr", mbus.mem_addr, addr);
      check("req_wdata", mbus.mem_wdata, regb);
      check("req_bubble", {31'd0, mem_wb_writereg}, 32'd0);
      if (mem_stall) stall_cnt++;
      // perturb inputs while busy; they must be ignored
      ex_mem_readmem  = 1'b1;
      ex_mem_writemem = ~wr_en;
      ex_mem_wbvalue  = $urandom;
      ex_mem_regb     = $urandom;
      ex_mem_writereg = 1'b1;
      ex_mem_regdest  = 5'd31;
      for (int unsigned i = 0; i < ack_delay; i++) begin
         mbus.mem_rdata = $urandom;
         tick();
         if (mem_stall) stall_cnt++;
         check("busy_addr", mbus.mem_addr, addr);
         check("busy_req", {31'd0, mbus.mem_req}, 32'd1);
         check("busy_bubble", {31'd0, mem_wb_writereg}, 32'd0);
      end
      mbus.mem_ack   = 1'b1;
      mbus.mem_rdata = rdata;
      tick();
      mbus.mem_ack   = 1'b0;
      mbus.mem_rdata = '0;
      idle_inputs();
      check("stall_cycles", stall_cnt, ack_delay + 1);
      check("done_stall", {31'd0, mem_stall}, 32'd0);
      check("done_req", {31'd0, mbus.mem_req}, 32'd0);
      check("done_wreg", {31'd0, mem_wb_writereg}, {31'd0, wreg});
      if (wreg) check("done_value", mem_wb_wbvalue, sel ? rdata : addr);
   endtask

   initial begin
      idle_inputs();
      mbus.mem_ack   = 1'b0;
      mbus.mem_rdata = '0;
      reset = 1'b0;
      #12;
      check("rst_req", {31'd0, mbus.mem_req}, 32'd0);
      check("rst_stall", {31'd0, mem_stall}, 32'd0);
      check("rst_addr", mbus.mem_addr, 32'd0);
      check("rst_wreg", {31'd0, mem_wb_writereg}, 32'd0);
      check("rst_value", mem_wb_wbvalue, 32'd0);
      check("rst_fault", {31'd0, mem_fault}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      tick();

      alu_op(5'd3, 32'h0000_0005, 1'b1);
      mbus.mem_ack = 1'b1;
      alu_op(5'd9, 32'hFFFF_FFFF, 1'b1);
      mbus.mem_ack = 1'b0;
      alu_op(5'd4, 32'h0000_0077, 1'b0);

      mem_op(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 5'd7, 1'b1, 3, 32'hDEAD_BEEF);
      mem_op(1'b0, 1'b1, 32'h200, 32'h1234, 1'b0, 5'd0, 1'b0, 0, 32'h0);
      mem_op(1'b1, 1'b1, 32'h300, 32'h5555, 1'b0, 5'd2, 1'b0, 1, 32'h0);
      mem_op(1'b1, 1'b0, 32'h440, 32'h0, 1'b0, 5'd12, 1'b1, 2, 32'hCAFE_0000);
      alu_op(5'd1, 32'h0000_0042, 1'b1);

      for (int i = 0; i < 6; i++) begin
         if ($urandom_range(0, 1) == 0)
            alu_op(5'($urandom), $urandom, 1'($urandom));
         else
            mem_op(1'b1, 1'($urandom), $urandom, $urandom, 1'($urandom), 5'($urandom),
                   1'($urandom), $urandom_range(0, 4), $urandom);
      end

      // reset during an access: abort, no writeback, later ack ignored
      ex_mem_readmem    = 1'b1;
      ex_mem_wbvalue    = 32'h800;
      ex_mem_selwsource = 1'b1;
      ex_mem_regdest    = 5'd5;
      ex_mem_writereg   = 1'b1;
      tick();
      idle_inputs();
      check("abort_busy", {31'd0, mem_stall}, 32'd1);
      #1 reset = 1'b0;
      #1;
      check("abort_req", {31'd0, mbus.mem_req}, 32'd0);
      check("abort_stall", {31'd0, mem_stall}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      mbus.mem_ack   = 1'b1;
      mbus.mem_rdata = 32'h1111_2222;
      tick();
      mbus.mem_ack = 1'b0;
      check("abort_ack_wreg", {31'd0, mem_wb_writereg}, 32'd0);
      check("abort_ack_stall", {31'd0, mem_stall}, 32'd0);

      // access that receives no ack
      ex_mem_readmem    = 1'b1;
      ex_mem_wbvalue    = 32'h900;
      ex_mem_selwsource = 1'b1;
      ex_mem_regdest    = 5'd6;
      ex_mem_writereg   = 1'b1;
      tick();
      idle_inputs();
`ifdef MEM_STAGE_TIMEOUT_EN
      begin
         int unsigned busy_cnt;
         busy_cnt = 0;
         while (mem_stall && busy_cnt < 40) begin
            check("tmo_nofault", {31'd0, mem_fault}, 32'd0);
            busy_cnt++;
            tick();
         end
         check("tmo_busy_cycles", busy_cnt, 32'd16);
         check("tmo_fault", {31'd0, mem_fault}, 32'd1);
         check("tmo_req", {31'd0, mbus.mem_req}, 32'd0);
         check("tmo_wreg", {31'd0, mem_wb_writereg}, 32'd0);
         tick();
         check("tmo_fault_pulse", {31'd0, mem_fault}, 32'd0);
      end
`else
      for (int i = 0; i < 40; i++) begin
         tick();
         check("wait_fault", {31'd0, mem_fault}, 32'd0);
      end
      check("wait_stall", {31'd0, mem_stall}, 32'd1);
      check("wait_req", {31'd0, mbus.mem_req}, 32'd1);
      sb.push_back('{rd: 5'd6, v: 32'hABCD_0123});
      mbus.mem_ack   = 1'b1;
      mbus.mem_rdata = 32'hABCD_0123;
      tick();
      mbus.mem_ack = 1'b0;
      check("wait_done_value", mem_wb_wbvalue, 32'hABCD_0123);
`endif
      alu_op(5'd8, 32'h0000_0808, 1'b1);
      tick();
      tick();
      check("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port: clock  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low; clears all state when 0.
REQ-003 SHALL have port: ex_mem_readmem  in  1  current instruction loads from data memory.
REQ-004 SHALL have port: ex_mem_writemem  in  1  current instruction stores to data memory.
REQ-005 SHALL have port: ex_mem_regb  in  32  store data.
REQ-006 SHALL have port: ex_mem_selwsource  in  1  writeback source; 1 = memory data, 0 = ex_mem_wbvalue.
REQ-007 SHALL have port: ex_mem_regdest  in  5  destination register.
REQ-008 SHALL have port: ex_mem_writereg  in  1  register write enable, already overflow-qualified.
REQ-009 SHALL have port: ex_mem_wbvalue  in  32  ALU/shifter result; also the memory address.
REQ-010 SHALL have port: mem_addr  out  32  data memory address.
REQ-011 SHALL have port: mem_wdata  out  32  data memory write data.
REQ-012 SHALL have port: mem_rw  out  1  1 = write, 0 = read.
REQ-013 SHALL have port: mem_req  out  1  request, held until acknowledged.
REQ-014 SHALL have port: mem_rdata  in  32  read data, valid with mem_ack.
REQ-015 SHALL have port: mem_ack  in  1  one-cycle completion pulse from memory.
REQ-016 SHALL have port: mem_stall  out  1  upstream freeze request.
REQ-017 SHALL have port: mem_wb_regdest  out  5  destination register to writeback.
REQ-018 SHALL have port: mem_wb_writereg  out  1  register write enable to writeback.
REQ-019 SHALL have port: mem_wb_wbvalue  out  32  value to write back.
REQ-020 SHALL have port: mem_fault  out  1  one-cycle pulse on access timeout.

Function
REQ-021 SHALL implement FSM states IDLE and BUSY.
REQ-022 In IDLE, a non-memory instruction (readmem = writemem = 0) SHALL be registered to the mem_wb_* outputs with 1-cycle latency: wbvalue <= ex_mem_wbvalue, regdest, writereg passed through.
REQ-023 In IDLE, readmem|writemem SHALL capture ex_mem_wbvalue into mem_addr and ex_mem_regb into mem_wdata, and SHALL also capture regdest, selwsource and writereg.
REQ-024 That same edge SHALL set mem_req=1, set mem_rw=writemem, move to BUSY and drive mem_wb_writereg=0 (bubble).
REQ-025 readmem=writemem=1 SHALL be treated as a write.
REQ-026 mem_stall SHALL equal (state==BUSY); it is combinational from state only.
REQ-027 In BUSY, ex_mem_* inputs SHALL be ignored, mem_addr/mem_wdata/mem_rw/mem_req SHALL stay stable, and mem_wb_writereg SHALL be 0 each cycle.
REQ-028 In BUSY, an edge with mem_ack=1 SHALL:
- clear mem_req and return to IDLE;
- set mem_wb_wbvalue = captured selwsource ? mem_rdata : captured address;
- set mem_wb_regdest and mem_wb_writereg from the captured values.
REQ-029 Minimum memory-op latency SHALL be 2 cycles (request edge, ack edge); mem_stall SHALL be high for exactly the number of cycles spent in BUSY.
REQ-030 mem_ack SHALL be ignored in IDLE.

Reset
REQ-031 reset=0 SHALL asynchronously force IDLE, mem_req=0, mem_rw=0, mem_addr=0, mem_wdata=0, mem_wb_wbvalue=0, mem_wb_regdest=0, mem_wb_writereg=0, mem_fault=0, timeout counter=0.
REQ-032 Reset during BUSY SHALL abort the access with no writeback; mem_stall SHALL fall immediately.

Configuration
REQ-033 Macro MEM_STAGE_TIMEOUT_EN defined: a 4-bit counter SHALL clear on entering BUSY and increment each BUSY cycle without ack.
REQ-034 With MEM_STAGE_TIMEOUT_EN, the 16th BUSY cycle without ack SHALL:
- return the FSM to IDLE and clear mem_req;
- keep mem_wb_writereg=0;
- pulse mem_fault for one cycle.
An ack arriving on that same edge SHALL win; no fault is raised.
REQ-035 Macro undefined: BUSY SHALL wait indefinitely, and mem_fault SHALL be constant 0 with no counter logic.

Verification
REQ-036 ALU op: wbvalue=0x0000_0005, regdest=3, writereg=1 -> next edge mem_wb = (3, 1, 0x5), mem_stall stays 0.
REQ-037 Load: readmem=1, wbvalue=0x100, selwsource=1, regdest=7; ack after 3 cycles with rdata=0xDEADBEEF -> mem_addr=0x100, mem_rw=0, stall high 4 cycles, then mem_wb = (7, 1, 0xDEADBEEF).
REQ-038 Store: writemem=1, wbvalue=0x200, regb=0x1234, writereg=0; immediate ack -> mem_rw=1, mem_wdata=0x1234, mem_wb_writereg=0, back in IDLE after 2 edges.
REQ-039 readmem=writemem=1 -> mem_rw=1; inputs changed during BUSY -> mem_addr unchanged.
REQ-040 reset pulled low mid-BUSY -> mem_req and mem_stall go 0 without a clock edge; a later ack is ignored.
REQ-041 With MEM_STAGE_TIMEOUT_EN, no ack -> mem_fault pulses on the 16th BUSY cycle, FSM returns to IDLE, no register write.
